board_ram: RTL and testbench
============================

# board_ram

Game-board storage for the 4x4 Sudoku design and the responder on the row-read interface used by the game checker. Holds four 24-bit row words and loads a built-in puzzle on request. Applies user digit edits while enforcing write protection on given cells. Serves registered row reads to the checker.

## Interface
- Parameters: none. Puzzle contents come from the shared package.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `RamAddr` in 2: row select from the checker.
- `RamDat` out 24: row word.
  - [23:20] write-protect, one bit per column.
  - [19:16] blank, one bit per column; 1 = blank.
  - [15:0] digits, column c at [4c+3:4c].
- `LoadReq` in 1: single-cycle pulse; load puzzle `PuzzleSel`.
- `PuzzleSel` in 2: puzzle index 0-3; sampled with `LoadReq`.
- `EditValid` in 1: edit request, sampled one cycle at a time.
- `EditRow` in 2: target row.
- `EditCol` in 2: target column.
- `EditDigit` in 4: value to write; 0 = erase, 1-4 = digit.
- `EditAck` out 1: one-cycle pulse; edit applied.
- `EditErr` out 1: one-cycle pulse; edit rejected.
- `Busy` out 1: high during LOAD or CLEAR.
- `Ready` out 1: high in READY.

## Operation
- **States:** IDLE, LOAD, READY, CLEAR.
- **Reset:** state IDLE; every row = 24'h0F0000 (all blank, unprotected). `RamDat`=0, `EditAck`=0, `EditErr`=0, `Busy`=0, `Ready`=0.
- **IDLE**
  - `LoadReq` -> LOAD with row counter 0; `PuzzleSel` is latched.
  - Edits are rejected.
- **LOAD**
  - Writes the package puzzle row[counter], one row per cycle, for 4 cycles. Then -> READY.
  - `LoadReq` is ignored in this state.
- **Puzzle row encoding**
  - A given cell has protect=1, blank=0, digit = its value.
  - An empty cell has protect=0, blank=1, digit = 0.
- **READY**
  - `LoadReq` -> LOAD; a new puzzle may replace the board at any time.
  - On `EditValid`, the edit is accepted only if all of these hold:
    - protect[EditCol] of row EditRow is 0.
    - `EditDigit` <= 4.
  - Accept, digit 1-4: write the digit field and clear the blank bit.
  - Accept, digit 0: set the digit field to 0 and set the blank bit.
  - Any other case: no write, `EditErr`.
- **Simultaneous `LoadReq` and `EditValid` in READY:** load wins and the edit gets `EditErr`.
- **Edits outside READY** (IDLE, LOAD, CLEAR): `EditErr`.
- **No duplicate-digit checking:** rule validation belongs to the checker.
- **Read port:** `RamDat` <= row[`RamAddr`] every cycle in every state.

## Timing
- **Read latency:** 1 cycle. `RamDat` at edge n+1 reflects `RamAddr` at edge n.
- **Read vs. write collision:** a read of a row written in the same cycle returns the old contents (read-before-write); the new value is visible one cycle later.
- **Edit response:** `EditValid` sampled at edge n gives `EditAck` or `EditErr` high during cycle n+1 for exactly one cycle. The write commits at edge n.
  - A back-to-back `EditValid` every cycle gets one response per request.
- **Load timing:** `LoadReq` at edge n.
  - `Busy`=1 from n+1 through n+4.
  - Rows 0-3 are written at edges n+1 through n+4.
  - `Ready`=1 from n+5.
- **Reset mid-LOAD or mid-CLEAR:** the board returns to all blank immediately and the state goes to IDLE; no partial puzzle remains.

## Configuration
- Macro `BOARD_CLEAR_ALL_EN`.
- **Defined:**
  - Adds input `ClearReq` (1 bit) and state CLEAR.
  - `ClearReq` in READY -> CLEAR for 4 cycles, one row per cycle. Each unprotected cell becomes blank with digit 0; protected cells are unchanged.
  - Then -> READY; `Busy` is high throughout.
  - `LoadReq` has priority over `ClearReq`.
- **Undefined:** no port and no CLEAR state; behaviour is otherwise identical.

## Structure
- **Package `sudoku_pkg`:**
  - Row word type and field offsets (DIG_LSB=0, BLANK_LSB=16, PROT_LSB=20).
  - State enum.
  - Blank-row constant 24'h0F0000.
  - Four-puzzle table of 4 rows each.
  - `MAX_DIGIT`=4.
- **Sub-module `board_cell_update`:** combinational row-word edit, taking row word, column and digit and producing the new word plus an accept flag. It is shared by the edit and clear paths.

## Test plan
1. Reset, then read rows 0-3 -> each `RamDat` = 24'h0F0000; `Ready`=0.
2. `LoadReq` with `PuzzleSel`=0 -> `Busy` high 4 cycles, `Ready` at n+5. Rows match the package table; a given 3 at row0 col1 reads protect bit 21=1, blank bit 17=0, [7:4]=3.
3. In READY, edit row0 col1 (protected) with digit 2 -> `EditErr` at n+1 and the word is unchanged. Edit a blank cell with digit 4 -> `EditAck`, digit=4, blank=0. Re-edit it with 0 -> blank=1. Digit 7 -> `EditErr`.
4. Same-cycle `LoadReq` + `EditValid` -> `EditErr` and the load proceeds. An edit to row 2 while `RamAddr`=2 -> the next `RamDat` is the old word and the following one is the new word.
5. Assert `RST` at cycle 2 of LOAD -> immediate IDLE and all rows 24'h0F0000. With `BOARD_CLEAR_ALL_EN`: fill 3 cells, `ClearReq` -> after 4 cycles all unprotected cells are blank and given cells are unchanged.

Source files
------------

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared definitions for the 4x4 Sudoku board storage.
//   - row_t: 24-bit row word {protect[3:0], blank[3:0], digits[15:0]}
//   - field offsets, blank-row constant, MAX_DIGIT
//   - state_e: board controller states
//   - puzzle_row(): built-in four-puzzle table, already encoded as row words
package sudoku_pkg;

    typedef logic [23:0] row_t;

    localparam int unsigned DIG_LSB   = 0;
    localparam int unsigned BLANK_LSB = 16;
    localparam int unsigned PROT_LSB  = 20;

    localparam row_t       BLANK_ROW = 24'h0F0000;
    localparam logic [3:0] MAX_DIGIT = 4'd4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StReady,
        StClear
    } state_e;

    // Given digits per puzzle row, column c at [4c+3:4c]; 0 = empty cell.
    function automatic logic [15:0] puzzle_digits(input logic [1:0] sel, input logic [1:0] row);
        logic [15:0] d;
        d = 16'h0000;
        case ({sel, row})
            4'b00_00: d = 16'h2030;
            4'b00_01: d = 16'h0104;
            4'b00_10: d = 16'h4010;
            4'b00_11: d = 16'h0302;
            4'b01_00: d = 16'h1000;
            4'b01_01: d = 16'h0020;
            4'b01_10: d = 16'h0300;
            4'b01_11: d = 16'h0004;
            4'b10_00: d = 16'h0001;
            4'b10_01: d = 16'h0200;
            4'b10_10: d = 16'h0030;
            4'b10_11: d = 16'h4000;
            4'b11_00: d = 16'h4300;
            4'b11_01: d = 16'h0012;
            4'b11_10: d = 16'h2100;
            4'b11_11: d = 16'h0034;
        endcase
        return d;
    endfunction

    // Given cell: protected, not blank. Empty cell: unprotected, blank, digit 0.
    function automatic row_t encode_row(input logic [15:0] dig);
        row_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            if (dig[4*c +: 4] != 4'd0) begin
                r[PROT_LSB + c]        = 1'b1;
                r[DIG_LSB + 4*c +: 4]  = dig[4*c +: 4];
            end else begin
                r[BLANK_LSB + c] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic row_t puzzle_row(input logic [1:0] sel, input logic [1:0] row);
        return encode_row(puzzle_digits(sel, row));
    endfunction

endpackage

// File: rtl/board_ram_if.sv
// board_ram_if: row-read, load and edit signals of the board storage.
//   RamAddr/RamDat        : registered row read port (checker side)
//   LoadReq/PuzzleSel     : built-in puzzle load request
//   EditValid/Row/Col/Digit, EditAck/EditErr : user digit edits
//   Busy/Ready            : controller status
//   ClearReq              : only with BOARD_CLEAR_ALL_EN defined
interface board_ram_if;
    import sudoku_pkg::*;

    logic [1:0] RamAddr;
    row_t       RamDat;
    logic       LoadReq;
    logic [1:0] PuzzleSel;
    logic       EditValid;
    logic [1:0] EditRow;
    logic [1:0] EditCol;
    logic [3:0] EditDigit;
    logic       EditAck;
    logic       EditErr;
    logic       Busy;
    logic       Ready;
`ifdef BOARD_CLEAR_ALL_EN
    logic       ClearReq;
`endif

    modport master (
`ifdef BOARD_CLEAR_ALL_EN
        output ClearReq,
`endif
        output RamAddr, LoadReq, PuzzleSel, EditValid, EditRow, EditCol, EditDigit,
        input  RamDat, EditAck, EditErr, Busy, Ready
    );

    modport slave (
`ifdef BOARD_CLEAR_ALL_EN
        input  ClearReq,
`endif
        input  RamAddr, LoadReq, PuzzleSel, EditValid, EditRow, EditCol, EditDigit,
        output RamDat, EditAck, EditErr, Busy, Ready
    );

endinterface

// File: rtl/board_cell_update.sv
// board_cell_update: combinational row-word edit shared by edit and clear paths.
//   i_row       : current row word
//   i_col       : target column (edit mode)
//   i_digit     : digit to write, 0 = erase (edit mode)
//   i_clear_all : 1 = blank every unprotected cell of the row
//   o_row       : updated row word (equals i_row when rejected)
//   o_accept    : edit allowed (always 1 in clear mode)
module board_cell_update
    import sudoku_pkg::*;
(
    input  row_t       i_row,
    input  logic [1:0] i_col,
    input  logic [3:0] i_digit,
    input  logic       i_clear_all,
    output row_t       o_row,
    output logic       o_accept
);

    always_comb begin
        o_row    = i_row;
        o_accept = 1'b0;
        if (i_clear_all) begin
            o_accept = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!i_row[PROT_LSB + c]) begin
                    o_row[BLANK_LSB + c]       = 1'b1;
                    o_row[DIG_LSB + 4*c +: 4]  = 4'd0;
                end
            end
        end else if (!i_row[PROT_LSB + 32'(i_col)] && (i_digit <= MAX_DIGIT)) begin
            o_accept                           = 1'b1;
            o_row[DIG_LSB + 4*32'(i_col) +: 4] = i_digit;
            o_row[BLANK_LSB + 32'(i_col)]      = (i_digit == 4'd0);
        end
    end

endmodule

// File: rtl/board_ram.sv
// board_ram: 4x4 Sudoku board storage with puzzle load, protected edits and a
// registered row-read port.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset (board all blank, state IDLE)
//   bus : board_ram_if.slave (read port, load, edit, status)
// Optional feature: BOARD_CLEAR_ALL_EN adds ClearReq and the CLEAR state, which
// blanks all unprotected cells one row per cycle.
module board_ram
    import sudoku_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    board_ram_if.slave  bus
);

    state_e     r_state, w_state_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    row_t       r_rows [4];
    row_t       w_rows_nxt [4];
    row_t       r_ram_dat;
    logic       r_ack, w_ack_nxt;
    logic       r_err, w_err_nxt;

    logic       w_clearing;
    logic [1:0] w_upd_row;
    row_t       w_upd_in, w_upd_out;
    logic       w_upd_accept;

`ifdef BOARD_CLEAR_ALL_EN
    assign w_clearing = (r_state == StClear);
`else
    assign w_clearing = 1'b0;
`endif

    // One update unit: the clear sweep walks rows by counter, edits use EditRow.
    assign w_upd_row = w_clearing ? r_cnt : bus.EditRow;
    assign w_upd_in  = r_rows[w_upd_row];

    board_cell_update u_cell_update (
        .i_row       (w_upd_in),
        .i_col       (bus.EditCol),
        .i_digit     (bus.EditDigit),
        .i_clear_all (w_clearing),
        .o_row       (w_upd_out),
        .o_accept    (w_upd_accept)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_rows_nxt  = r_rows;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.LoadReq) begin
                    w_state_nxt = StLoad;
                    w_cnt_nxt   = 2'd0;
                    w_sel_nxt   = bus.PuzzleSel;
                end
            end
            StLoad: begin
                w_rows_nxt[r_cnt] = puzzle_row(r_sel, r_cnt);
                w_cnt_nxt         = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = StReady;
                end
            end
            StReady: begin
                if (bus.LoadReq) begin
                    w_state_nxt = StLoad;
                    w_cnt_nxt   = 2'd0;
                    w_sel_nxt   = bus.PuzzleSel;
`ifdef BOARD_CLEAR_ALL_EN
                end else if (bus.ClearReq) begin
                    w_state_nxt = StClear;
                    w_cnt_nxt   = 2'd0;
`endif
                end else if (bus.EditValid && w_upd_accept) begin
                    w_rows_nxt[bus.EditRow] = w_upd_out;
                    w_ack_nxt               = 1'b1;
                end
            end
`ifdef BOARD_CLEAR_ALL_EN
            StClear: begin
                w_rows_nxt[r_cnt] = w_upd_out;
                w_cnt_nxt         = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = StReady;
                end
            end
`endif
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Every request not applied above (wrong state, protected, bad digit,
        // lost to a load or clear) gets an error pulse.
        w_err_nxt = bus.EditValid && !w_ack_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= StIdle;
            r_cnt     <= 2'd0;
            r_sel     <= 2'd0;
            r_ram_dat <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_rows[i] <= BLANK_ROW;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_rows    <= w_rows_nxt;
            // Reads the pre-edge contents, so a same-cycle write shows up a cycle later.
            r_ram_dat <= r_rows[bus.RamAddr];
        end
    end

    assign bus.RamDat  = r_ram_dat;
    assign bus.EditAck = r_ack;
    assign bus.EditErr = r_err;
    assign bus.Busy    = (r_state == StLoad) || (r_state == StClear);
    assign bus.Ready   = (r_state == StReady);

endmodule

// File: tb/tb_board_ram.sv
// tb_board_ram: scoreboard bench for board_ram. Stimulus pushes expected read
// words, edit responses and status values into queues; a negedge monitor pops
// and compares whenever the DUT presents the corresponding output.
// Define BOARD_CLEAR_ALL_EN to also exercise the clear sweep.
module tb_board_ram;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    board_ram_if bus ();

    board_ram dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    localparam logic [1:0]  ACK = 2'b01;
    localparam logic [1:0]  ERR = 2'b10;
    localparam logic [23:0] BLK = 24'h0F0000;

    typedef struct {
        logic        busy;
        logic        ready;
        logic        chk_dat;
        logic [23:0] dat;
        string       nm;
    } st_exp_t;

    logic [23:0] rd_q [$];
    string       rd_nm_q [$];
    logic [1:0]  ed_q [$];
    string       ed_nm_q [$];
    st_exp_t     st_q [$];

    logic rd_req, rd_vld, st_req;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    function automatic void fail_now(input string nm);
        n_checks++;
        $display("FAIL %s", nm);
    endfunction

    // A read issued in one cycle is answered after the following edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) rd_vld <= 1'b0;
        else     rd_vld <= rd_req;
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (rd_vld) begin
                if (rd_q.size() == 0) begin
                    fail_now("read data with empty scoreboard");
                end else begin
                    check(rd_nm_q.pop_front(), bus.RamDat, rd_q.pop_front());
                end
            end
            if (bus.EditAck || bus.EditErr) begin
                if (ed_q.size() == 0) begin
                    fail_now("unexpected edit response");
                end else begin
                    check(ed_nm_q.pop_front(), {22'h0, bus.EditErr, bus.EditAck},
                          {22'h0, ed_q.pop_front()});
                end
            end
            if (st_req) begin
                if (st_q.size() == 0) begin
                    fail_now("status check with empty scoreboard");
                end else begin
                    st_exp_t e;
                    e = st_q.pop_front();
                    check({e.nm, " busy/ready"}, {22'h0, bus.Busy, bus.Ready},
                          {22'h0, e.busy, e.ready});
                    if (e.chk_dat) check({e.nm, " RamDat"}, bus.RamDat, e.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        rd_req        = 1'b0;
        st_req        = 1'b0;
        bus.LoadReq   = 1'b0;
        bus.EditValid = 1'b0;
`ifdef BOARD_CLEAR_ALL_EN
        bus.ClearReq  = 1'b0;
`endif
    endtask

    task automatic rd(input logic [1:0] a, input logic [23:0] exp, input string nm);
        bus.RamAddr = a;
        rd_req      = 1'b1;
        rd_q.push_back(exp);
        rd_nm_q.push_back(nm);
    endtask

    task automatic edit(input logic [1:0] r, input logic [1:0] c, input logic [3:0] d,
                        input logic [1:0] exp, input string nm);
        bus.EditValid = 1'b1;
        bus.EditRow   = r;
        bus.EditCol   = c;
        bus.EditDigit = d;
        ed_q.push_back(exp);
        ed_nm_q.push_back(nm);
    endtask

    task automatic status(input logic b, input logic r, input logic chk, input logic [23:0] dat,
                          input string nm);
        st_exp_t e;
        e.busy    = b;
        e.ready   = r;
        e.chk_dat = chk;
        e.dat     = dat;
        e.nm      = nm;
        st_q.push_back(e);
        st_req = 1'b1;
    endtask

    task automatic load(input logic [1:0] sel);
        bus.LoadReq   = 1'b1;
        bus.PuzzleSel = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST           = 1'b1;
        rd_req        = 1'b0;
        st_req        = 1'b0;
        bus.RamAddr   = 2'd0;
        bus.LoadReq   = 1'b0;
        bus.PuzzleSel = 2'd0;
        bus.EditValid = 1'b0;
        bus.EditRow   = 2'd0;
        bus.EditCol   = 2'd0;
        bus.EditDigit = 4'd0;
`ifdef BOARD_CLEAR_ALL_EN
        bus.ClearReq  = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state and blank board.
        status(1'b0, 1'b0, 1'b1, 24'h0, "reset outputs");
        rd(2'd0, BLK, "reset row0");
        tick(); rd(2'd1, BLK, "reset row1");
        tick(); rd(2'd2, BLK, "reset row2");
        tick(); rd(2'd3, BLK, "reset row3");

        // Load puzzle 0; a second LoadReq mid-load and an edit mid-load are refused.
        tick(); status(1'b0, 1'b0, 1'b0, 24'h0, "idle before load"); load(2'd0);
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "load cycle 1");
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "load cycle 2"); load(2'd1);
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "load cycle 3");
        edit(2'd3, 2'd1, 4'd1, ERR, "edit during load");
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "load cycle 4");
        tick(); status(1'b0, 1'b1, 1'b0, 24'h0, "ready after load");
        rd(2'd0, 24'hA52030, "p0 row0");
        tick(); rd(2'd1, 24'h5A0104, "p0 row1");
        tick(); rd(2'd2, 24'hA54010, "p0 row2");
        tick(); rd(2'd3, 24'h5A0302, "p0 row3");

        // Back-to-back edits.
        tick(); edit(2'd0, 2'd1, 4'd2, ERR, "edit protected cell");
        tick(); edit(2'd0, 2'd0, 4'd4, ACK, "edit digit 4");
        tick(); edit(2'd1, 2'd1, 4'd3, ACK, "edit row1 digit 3");
        tick(); edit(2'd0, 2'd0, 4'd7, ERR, "edit digit 7");
        tick(); edit(2'd0, 2'd0, 4'd5, ERR, "edit digit 5");
        rd(2'd0, 24'hA42034, "row0 after digit 4");
        tick(); rd(2'd1, 24'h580134, "row1 after digit 3");
        tick(); edit(2'd0, 2'd0, 4'd0, ACK, "erase cell");
        tick(); rd(2'd0, 24'hA52030, "row0 after erase");

        // Read-before-write on the same row.
        tick(); edit(2'd2, 2'd0, 4'd1, ACK, "edit row2");
        rd(2'd2, 24'hA54010, "collision old word");
        tick(); rd(2'd2, 24'hA44011, "collision new word");

        // Load wins over a same-cycle edit.
        tick(); load(2'd1); edit(2'd2, 2'd0, 4'd2, ERR, "edit vs load");
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "reload cycle 1");
        tick(); tick(); tick();
        tick(); status(1'b0, 1'b1, 1'b0, 24'h0, "ready after reload");
        rd(2'd0, 24'h871000, "p1 row0");
        tick(); rd(2'd2, 24'h4B0300, "p1 row2");

        // Reset during the second load cycle.
        tick(); load(2'd0);
        tick();
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        status(1'b0, 1'b0, 1'b1, 24'h0, "reset mid-load");
        rd(2'd0, BLK, "row0 after mid-load reset");
        edit(2'd0, 2'd0, 4'd1, ERR, "edit in idle");
        tick(); rd(2'd1, BLK, "row1 after mid-load reset");
        tick(); rd(2'd2, BLK, "row2 after mid-load reset");
        tick(); rd(2'd3, BLK, "row3 after mid-load reset");

`ifdef BOARD_CLEAR_ALL_EN
        // Fill three cells, then sweep them away; givens survive.
        tick(); load(2'd0);
        tick(); tick(); tick(); tick();
        tick(); status(1'b0, 1'b1, 1'b0, 24'h0, "ready before clear");
        edit(2'd0, 2'd0, 4'd1, ACK, "fill row0");
        tick(); edit(2'd1, 2'd1, 4'd2, ACK, "fill row1");
        tick(); edit(2'd3, 2'd3, 4'd4, ACK, "fill row3");
        tick(); bus.ClearReq = 1'b1;
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "clear cycle 1");
        tick(); tick();
        tick(); status(1'b1, 1'b0, 1'b0, 24'h0, "clear cycle 4");
        tick(); status(1'b0, 1'b1, 1'b0, 24'h0, "ready after clear");
        rd(2'd0, 24'hA52030, "row0 after clear");
        tick(); rd(2'd1, 24'h5A0104, "row1 after clear");
        tick(); rd(2'd2, 24'hA54010, "row2 after clear");
        tick(); rd(2'd3, 24'h5A0302, "row3 after clear");
`endif

        repeat (3) tick();

        check("read scoreboard drained", 24'(rd_q.size()), 24'd0);
        check("edit scoreboard drained", 24'(ed_q.size()), 24'd0);
        check("status scoreboard drained", 24'(st_q.size()), 24'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
